// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the set-associative cache.
package cache_pkg;
  localparam int ADDR_W  = 32;
  localparam int WORD_AW = 30;  // address bits above the byte offset

  typedef enum logic {ST_INIT, ST_IDLE} cache_state_e;

  // tag field is sized for the widest possible tag and zero-extended
  typedef struct packed {
    logic               dirty;
    logic               valid;
    logic [WORD_AW-1:0] tag;
  } tag_entry_t;

  function automatic int sets_of(input int cache_size, input int line_size, input int ways);
    return cache_size / (line_size * ways);
  endfunction

  function automatic int idx_w(input int cache_size, input int line_size, input int ways);
    return $clog2(sets_of(cache_size, line_size, ways));
  endfunction

  function automatic int tag_w(input int cache_size, input int line_size, input int ways);
    return WORD_AW - idx_w(cache_size, line_size, ways);
  endfunction
endpackage

// File: rtl/bram.sv
// Simple dual-port block RAM: bit-masked write, registered read that holds
// its last value while re is low.
module bram #(
  parameter int DW = 32,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [DW-1:0] wmask,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: node bit 0 steers the victim left, 1 right.
// Heap layout: node n has children 2n+1 / 2n+2, way w is leaf WAYS-1+w.
module plru_tree #(
  parameter int WAYS = 2,
  parameter int WW   = (WAYS > 1) ? $clog2(WAYS) : 1,
  parameter int PB   = (WAYS > 1) ? WAYS - 1 : 1
) (
  input  logic [PB-1:0] state,
  input  logic [WW-1:0] acc_way,
  output logic [WW-1:0] victim,
  output logic [PB-1:0] state_nxt
);
  logic [2*WAYS-2:0] on_path;

  always_comb begin
    on_path    = '0;
    on_path[0] = 1'b1;
    for (int n = 0; n < WAYS - 1; n++) begin
      on_path[2*n+1] = on_path[n] & ~state[n];
      on_path[2*n+2] = on_path[n] &  state[n];
    end
    victim = '0;
    for (int w = 0; w < WAYS; w++)
      if (on_path[WAYS-1+w]) victim = WW'(w);
  end

  // walk leaf-to-root and point every ancestor away from the accessed way
  always_comb begin
    state_nxt = state;
    for (int w = 0; w < WAYS; w++)
      if (acc_way == WW'(w))
        for (int c = WAYS - 1 + w; c > 0; c = (c - 1) / 2)
          state_nxt[(c-1)/2] = c[0];
  end
endmodule

// File: rtl/set_assoc_cache.sv
// Set-associative, one-word-per-line cache with tree-PLRU replacement.
// Lookup results appear the cycle after req_valid and hold until the next lookup.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int LINE_SIZE  = 4,
  parameter int CACHE_SIZE = 1024,
  parameter int WAYS       = 2,
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   addr,
  input  logic          req_valid,
  input  logic          write_valid,
  input  logic          write_access,
  input  logic [31:0]   write_data,
  input  logic [3:0]    write_strb,
  output logic          ready,
  output logic          hit,
  output logic [WW-1:0] hit_way,
  output logic          dirty,
  output logic [31:0]   data,
  output logic [31:0]   invalidate_addr
);
  localparam int SETS = sets_of(CACHE_SIZE, LINE_SIZE, WAYS);
  localparam int IW   = idx_w(CACHE_SIZE, LINE_SIZE, WAYS);
  localparam int TW   = tag_w(CACHE_SIZE, LINE_SIZE, WAYS);
  localparam int PB   = (WAYS > 1) ? WAYS - 1 : 1;

  cache_state_e  state, state_nxt;
  logic [IW-1:0] init_idx;

  logic [IW-1:0]      a_idx;
  logic [WORD_AW-1:0] a_tag;
  logic               unused_offset;
  assign a_idx         = addr[IW+1:2];
  assign a_tag         = WORD_AW'(addr[ADDR_W-1 -: TW]);
  assign unused_offset = &{1'b0, addr[1:0]};

  logic rd_en, wr_en;
  assign ready = (state == ST_IDLE);
  assign rd_en = ready & ~rst & req_valid & ~write_valid;
  assign wr_en = ready & ~rst & write_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_idx <= init_idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && init_idx == IW'(SETS - 1)) state_nxt = ST_IDLE;
  end

  // lookup context; lk_first marks the cycle right after a lookup
  logic               lk_vld, lk_first, wr_done;
  logic [IW-1:0]      lk_idx;
  logic [WORD_AW-1:0] lk_tag;
  logic [WW-1:0]      target_q;

  tag_entry_t [WAYS-1:0]       ent;
  logic [WAYS-1:0][31:0]       line;
  logic [WAYS-1:0]             match, tag_we;
  logic                        hit_c, inv_any;
  logic [WW-1:0]               hit_idx, inv_way, plru_victim, sel_c, sel_way;
  logic [SETS-1:0][PB-1:0]     plru_q;
  logic [PB-1:0]               plru_nxt;
  logic [IW-1:0]               p_idx, tag_waddr;
  tag_entry_t                  tag_wdata;
  logic [31:0]                 strb_mask, dat_wdata, dat_wmask;
  logic                        wr_hit, hit_upd;

  always_comb begin
    match   = '0;
    hit_idx = '0;
    inv_way = '0;
    inv_any = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      match[w] = ent[w].valid && (ent[w].tag == lk_tag);
      if (match[w]) hit_idx = WW'(w);
      if (!ent[w].valid) begin
        inv_any = 1'b1;
        inv_way = WW'(w);
      end
    end
  end

  assign hit_c   = $onehot(match);
  assign sel_c   = hit_c ? hit_idx : (inv_any ? inv_way : plru_victim);
  assign sel_way = lk_first ? sel_c : target_q;
  assign p_idx   = wr_en ? a_idx : lk_idx;
  // after one write the line is resident, so a second store merges in place
  assign wr_hit  = (lk_vld & hit_c) | wr_done;
  assign hit_upd = ~rst & lk_first & hit_c;

  plru_tree #(.WAYS(WAYS)) u_plru (
    .state    (plru_q[p_idx]),
    .acc_way  (sel_way),
    .victim   (plru_victim),
    .state_nxt(plru_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_vld   <= 1'b0;
      lk_first <= 1'b0;
      wr_done  <= 1'b0;
      lk_idx   <= '0;
      lk_tag   <= '0;
      target_q <= '0;
    end else begin
      lk_first <= rd_en;
      if (rd_en) begin
        lk_vld  <= 1'b1;
        lk_idx  <= a_idx;
        lk_tag  <= a_tag;
        wr_done <= 1'b0;
      end else if (wr_en) begin
        wr_done <= 1'b1;
      end
      if (lk_first) target_q <= sel_c;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_INIT)  plru_q[init_idx] <= '0;
    else if (wr_en)        plru_q[a_idx]    <= plru_nxt;
    else if (hit_upd)      plru_q[lk_idx]   <= plru_nxt;
  end

  always_comb begin
    for (int b = 0; b < 4; b++) strb_mask[b*8 +: 8] = {8{write_strb[b]}};
  end

  always_comb begin
    tag_we    = '0;
    tag_waddr = a_idx;
    tag_wdata = '0;
    dat_wdata = write_data;
    dat_wmask = '1;
    if (state == ST_INIT) begin
      tag_we    = '1;
      tag_waddr = init_idx;
    end else if (wr_en) begin
      tag_we[sel_way] = 1'b1;
      tag_wdata       = '{dirty: write_access, valid: 1'b1, tag: a_tag};
      if (write_access) begin
        if (wr_hit) dat_wmask = strb_mask;
        else        dat_wdata = write_data & strb_mask;
      end
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic way_we;
    assign way_we = wr_en & (sel_way == WW'(w));

    bram #(.DW($bits(tag_entry_t)), .AW(IW)) u_tag (
      .clk  (clk),
      .we   (tag_we[w]),
      .waddr(tag_waddr),
      .wdata(tag_wdata),
      .wmask({$bits(tag_entry_t){1'b1}}),
      .re   (rd_en),
      .raddr(a_idx),
      .rdata(ent[w])
    );

    bram #(.DW(32), .AW(IW)) u_data (
      .clk  (clk),
      .we   (way_we),
      .waddr(a_idx),
      .wdata(dat_wdata),
      .wmask(dat_wmask),
      .re   (rd_en),
      .raddr(a_idx),
      .rdata(line[w])
    );
  end

  assign hit             = lk_vld & hit_c;
  assign hit_way         = lk_vld ? sel_way : '0;
  assign dirty           = lk_vld & ent[sel_way].dirty;
  assign data            = lk_vld ? line[sel_way] : '0;
  assign invalidate_addr = lk_vld ? ((32'(ent[sel_way].tag) << (IW + 2)) | (32'(lk_idx) << 2)) : '0;
endmodule

// File: tb/tb_set_assoc_cache.sv
// Randomized bench for set_assoc_cache (defaults: 128 sets x 2 ways) against
// a per-set array model with MRU-based replacement.
module tb_set_assoc_cache;
  localparam int SETS = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        req_valid, write_valid, write_access;
  logic [31:0] write_data;
  logic [3:0]  write_strb;
  logic        ready, hit, dirty;
  logic [0:0]  hit_way;
  logic [31:0] data, invalidate_addr;

  set_assoc_cache dut (
    .clk(clk), .rst(rst), .addr(addr), .req_valid(req_valid),
    .write_valid(write_valid), .write_access(write_access),
    .write_data(write_data), .write_strb(write_strb), .ready(ready),
    .hit(hit), .hit_way(hit_way), .dirty(dirty), .data(data),
    .invalidate_addr(invalidate_addr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model: per set, per way; mru holds the most recently touched way
  logic        m_valid [SETS][2];
  logic        m_dirty [SETS][2];
  logic [22:0] m_tag   [SETS][2];
  logic [31:0] m_data  [SETS][2];
  int          mru     [SETS];

  logic        e_any, e_hit, e_vv, e_dirty;
  logic [31:0] e_data, e_inv;
  int          tgt;
  logic        wrote;

  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", t, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
      mru[s] = 1;
    end
    e_any = 1'b0;
    wrote = 1'b0;
  endtask

  task automatic chk_outs(input string t);
    if (!e_any) begin
      chk({t, "_hit0"}, 32'(hit), 32'd0);
      chk({t, "_data0"}, data, 32'd0);
      chk({t, "_dirty0"}, 32'(dirty), 32'd0);
      chk({t, "_inv0"}, invalidate_addr, 32'd0);
      chk({t, "_way0"}, 32'(hit_way), 32'd0);
    end else begin
      chk({t, "_hit"}, 32'(hit), 32'(e_hit));
      if (e_hit) begin
        chk({t, "_way"}, 32'(hit_way), 32'(tgt));
        chk({t, "_data"}, data, e_data);
        chk({t, "_dirty"}, 32'(dirty), 32'(e_dirty));
      end else if (e_vv) begin
        chk({t, "_vdata"}, data, e_data);
        chk({t, "_vdirty"}, 32'(dirty), 32'(e_dirty));
        chk({t, "_vinv"}, invalidate_addr, e_inv);
      end else begin
        chk({t, "_idirty"}, 32'(dirty), 32'd0);
      end
    end
  endtask

  // starts and ends on a negedge
  task automatic do_lookup(input logic [31:0] a);
    int s;
    int hw;
    logic [22:0] tg;
    s  = int'(a[8:2]);
    tg = a[31:9];
    hw = -1;
    for (int w = 0; w < 2; w++)
      if (m_valid[s][w] && m_tag[s][w] == tg) hw = w;
    if (hw >= 0) begin
      e_hit  = 1'b1;
      tgt    = hw;
      mru[s] = hw;
    end else begin
      e_hit = 1'b0;
      tgt   = -1;
      for (int w = 1; w >= 0; w--) if (!m_valid[s][w]) tgt = w;
      if (tgt < 0) tgt = 1 - mru[s];
    end
    e_any   = 1'b1;
    e_vv    = m_valid[s][tgt];
    e_data  = m_data[s][tgt];
    e_dirty = m_dirty[s][tgt];
    e_inv   = {m_tag[s][tgt], 7'(s), 2'b00};
    wrote   = 1'b0;
    addr = a;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk_outs("lk");
  endtask

  task automatic do_write(input logic [31:0] a, input logic acc, input logic [31:0] d,
                          input logic [3:0] sb, input logic with_req);
    int s;
    logic [31:0] mask;
    s = int'(a[8:2]);
    for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{sb[b]}};
    if (!acc)       m_data[s][tgt] = d;
    else if (e_hit) m_data[s][tgt] = (m_data[s][tgt] & ~mask) | (d & mask);
    else            m_data[s][tgt] = d & mask;
    m_valid[s][tgt] = 1'b1;
    m_dirty[s][tgt] = acc;
    m_tag[s][tgt]   = a[31:9];
    mru[s]          = tgt;
    addr = a;
    write_access = acc;
    write_data = d;
    write_strb = sb;
    write_valid = 1'b1;
    req_valid = with_req;
    @(negedge clk);
    write_valid = 1'b0;
    req_valid = 1'b0;
    wrote = 1'b1;
  endtask

  initial begin
    int n;
    int mode;
    logic [31:0] a;
    rst = 1'b1;
    addr = '0;
    req_valid = 1'b0;
    write_valid = 1'b0;
    write_access = 1'b0;
    write_data = '0;
    write_strb = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_outs("rst");
    chk("rst_ready", 32'(ready), 32'd0);

    rst = 1'b0;
    for (int c = 0; c <= SETS; c++) begin
      chk("init_ready", 32'(ready), (c == SETS) ? 32'd1 : 32'd0);
      if (c < SETS) @(negedge clk);
    end
    chk_outs("idle");

    // refill, hit, partial store
    do_lookup(32'h0000_1000);
    chk("cold_hit", 32'(hit), 32'd0);
    do_write(32'h0000_1000, 1'b0, 32'hDEAD_BEEF, 4'hF, 1'b0);
    do_lookup(32'h0000_1000);
    chk("r26_hit", 32'(hit), 32'd1);
    chk("r26_data", data, 32'hDEAD_BEEF);
    chk("r26_dirty", 32'(dirty), 32'd0);
    do_write(32'h0000_1000, 1'b1, 32'h0000_1234, 4'b0011, 1'b0);
    chk_outs("r27_hold");
    do_lookup(32'h0000_1000);
    chk("r27_data", data, 32'hDEAD_1234);
    chk("r27_dirty", 32'(dirty), 32'd1);

    // replacement within set 0
    do_lookup(32'h0000_2000);
    do_write(32'h0000_2000, 1'b0, 32'h2222_0000, 4'hF, 1'b0);
    do_lookup(32'h0000_1000);
    chk("r28_hitway", 32'(hit_way), 32'd0);
    do_lookup(32'h0000_3000);
    chk("r28_miss", 32'(hit), 32'd0);
    chk("r28_inv", invalidate_addr, 32'h0000_2000);
    chk("r28_vdata", data, 32'h2222_0000);

    // write together with a lookup: write lands, outputs stay
    do_lookup(32'h0000_1000);
    do_write(32'h0000_1000, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b1);
    chk_outs("r30_hold");
    chk("r30_old_data", data, 32'hDEAD_1234);
    do_lookup(32'h0000_1000);
    chk("r30_new_data", data, 32'hCAFE_F00D);

    for (int it = 0; it < 400; it++) begin
      a = (32'($urandom_range(1, 6)) << 9) | (32'($urandom_range(0, 3)) << 2) |
          32'($urandom_range(0, 3));
      do_lookup(a);
      mode = $urandom_range(0, 3);
      if (mode == 2) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        chk_outs("idle_hold");
      end
      if (mode != 0) begin
        do_write(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), mode == 3);
        chk_outs("wr_hold");
      end
    end

    // reset from operation, then again at sweep index 60, with traffic during INIT
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (60) @(negedge clk);
    rst = 1'b1;
    addr = 32'h0000_1000;
    write_access = 1'b0;
    write_data = 32'h1234_5678;
    write_strb = 4'hF;
    write_valid = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
      if (n == 5) begin
        write_valid = 1'b0;
        req_valid = 1'b0;
      end
    end
    chk("rst60_latency", 32'(n), 32'(SETS));
    chk_outs("rst60_idle");
    do_lookup(32'h0000_1000);
    chk("rst60_miss", 32'(hit), 32'd0);
    do_lookup(32'h0000_2000);
    chk("rst60_miss2", 32'(hit), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
